// File: rtl/edge_event_arbiter_pkg.sv
// Purpose : shared types and limits for the edge-event arbiter block.
// Latency : n/a (types only).
// Backpressure : n/a.
package edge_arb_pkg;

  localparam int NCH_MAX = 16;

  typedef enum logic {POL_FALL = 1'b0, POL_RISE = 1'b1} evt_pol_e;
  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} arb_state_e;

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Purpose : single-event valid/ready reporting port (channel index + polarity).
// Latency : n/a (wires only).
// Backpressure : master holds evt_ch/evt_pol stable while evt_valid & ~evt_ready.
// Ports   : evt_valid, evt_ch, evt_pol (master out), evt_ready (slave out).
interface edge_event_arbiter_if
  import edge_arb_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
);

  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_ch;
  evt_pol_e      evt_pol;

  modport master (output evt_valid, output evt_ch, output evt_pol, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_pol, output evt_ready);

endinterface

// File: rtl/edge_event_arbiter_capture.sv
// Purpose : one-channel edge detector holding a single pending event and a sticky overflow flag.
// Latency : pend_o/pol_o/ovf_o update on the edge that samples the input change.
// Backpressure : a new edge while pending is dropped (oldest kept) and flags ovf_o.
// Ports   : sig_i/mode_rise_i/mode_fall_i detection inputs, prime_i suppresses detection,
//           clr_pend_i retires the pending event, ovf_clr_i clears ovf_o;
//           pend_o/pol_o pending event, ovf_o sticky lost-event flag.
module edge_capture_ch
  import edge_arb_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     sig_i,
  input  logic     mode_rise_i,
  input  logic     mode_fall_i,
  input  logic     clr_pend_i,
  input  logic     ovf_clr_i,
  input  logic     prime_i,
  output logic     pend_o,
  output evt_pol_e pol_o,
  output logic     ovf_o
);

  logic     sig_q;
  logic     pend_q, pend_d;
  logic     ovf_q, ovf_d;
  evt_pol_e pol_q, pol_d;
  logic     rise, fall, det;

  // Prime cycle only loads sig_q so an input already high at reset release is not an edge.
  assign rise = ~prime_i &  sig_i & ~sig_q & mode_rise_i;
  assign fall = ~prime_i & ~sig_i &  sig_q & mode_fall_i;
  assign det  = rise | fall;

  always_comb begin
    pend_d = pend_q;
    pol_d  = pol_q;
    ovf_d  = ovf_q;
    if (ovf_clr_i) ovf_d = 1'b0;
    if (det) begin
      // A slot freed by this cycle's handshake can take the new event without loss.
      if (!pend_q || clr_pend_i) begin
        pend_d = 1'b1;
        pol_d  = rise ? POL_RISE : POL_FALL;
      end else begin
        ovf_d = 1'b1;  // overrides a same-cycle clear
      end
    end else if (clr_pend_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q  <= 1'b0;
      pend_q <= 1'b0;
      pol_q  <= POL_FALL;
      ovf_q  <= 1'b0;
    end else begin
      sig_q  <= sig_i;
      pend_q <= pend_d;
      pol_q  <= pol_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend_o = pend_q;
  assign pol_o  = pol_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Purpose : NCH edge detectors sharing one valid/ready event port via round-robin arbitration.
// Latency : input change to evt_valid is 2 cycles; one event per 2 cycles at best.
// Backpressure : offered event held stable until evt_ready; channels keep one pending event each.
// Ports   : clk_i, rst_ni (async active-low), sig_i/mode_rise_i/mode_fall_i per channel,
//           ovf_clr_i clears ovf_o, evt (master) carries evt_valid/evt_ready/evt_ch/evt_pol.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter  int NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NCH-1:0]       sig_i,
  input  logic [NCH-1:0]       mode_rise_i,
  input  logic [NCH-1:0]       mode_fall_i,
  input  logic                 ovf_clr_i,
  output logic [NCH-1:0]       ovf_o,
  edge_event_arbiter_if.master evt
);

  if (NCH < 2 || NCH > NCH_MAX) begin : g_bad_nch
    $error("edge_event_arbiter: NCH out of range");
  end

  arb_state_e    state_q, state_d;
  logic [CW-1:0] last_ptr_q, last_ptr_d;
  logic [CW-1:0] ch_q, ch_d;
  evt_pol_e      pol_q, pol_d;
  logic          prime_q;

  logic [NCH-1:0] pend, pol_vec, clr_pend;
  logic           hs;
  logic           sel_vld;
  logic [CW-1:0]  sel_idx;
  int             idx;

  assign hs = (state_q == OFFER) & evt.evt_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign clr_pend[i] = hs & (ch_q == CW'(i));

    edge_capture_ch u_ch (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .sig_i      (sig_i[i]),
      .mode_rise_i(mode_rise_i[i]),
      .mode_fall_i(mode_fall_i[i]),
      .clr_pend_i (clr_pend[i]),
      .ovf_clr_i  (ovf_clr_i),
      .prime_i    (prime_q),
      .pend_o     (pend[i]),
      .pol_o      (pol_vec[i]),
      .ovf_o      (ovf_o[i])
    );
  end

  // Round-robin: scan from the channel after the last one served, wrapping once.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(last_ptr_q) + k) % NCH;
      if (!sel_vld && pend[idx]) begin
        sel_vld = 1'b1;
        sel_idx = CW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    pol_d      = pol_q;
    last_ptr_d = last_ptr_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = OFFER;
          ch_d    = sel_idx;
          pol_d   = evt_pol_e'(pol_vec[sel_idx]);
        end
      end
      OFFER: begin
        if (evt.evt_ready) begin
          state_d    = IDLE;
          last_ptr_d = ch_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      last_ptr_q <= CW'(NCH - 1);  // channel 0 wins the first arbitration
      ch_q       <= '0;
      pol_q      <= POL_FALL;
      prime_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_ptr_q <= last_ptr_d;
      ch_q       <= ch_d;
      pol_q      <= pol_d;
      prime_q    <= 1'b0;
    end
  end

  // Decoded straight from the state register so reset drops it without waiting for a clock.
  assign evt.evt_valid = (state_q == OFFER);
  assign evt.evt_ch    = ch_q;
  assign evt.evt_pol   = pol_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] sig;
  logic [3:0] mode_rise;
  logic [3:0] mode_fall;
  logic       ovf_clr;
  logic [3:0] ovf;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0] ch;
    logic       pol;
  } exp_t;
  exp_t exp_q[$];

  edge_event_arbiter_if #(.NCH(4)) evt_if();

  edge_event_arbiter #(.NCH(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sig_i      (sig),
    .mode_rise_i(mode_rise),
    .mode_fall_i(mode_fall),
    .ovf_clr_i  (ovf_clr),
    .ovf_o      (ovf),
    .evt        (evt_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic pol);
    exp_t e;
    e.ch  = ch;
    e.pol = pol;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input logic [3:0] sig_val);
    rst_n = 1'b0;
    sig   = sig_val;
    step(2);
    rst_n = 1'b1;
    step(1);  // prime cycle
  endtask

  // Four events offered in channel order 0..3, each two cycles apart.
  task automatic batch(input logic pol);
    step(2);
    for (int k = 0; k < 4; k++) begin
      chk("batch_valid", evt_if.evt_valid, 1'b1);
      chk("batch_ch", evt_if.evt_ch, k);
      chk("batch_pol", evt_if.evt_pol, pol);
      step(1);
      chk("batch_gap", evt_if.evt_valid, 1'b0);
      step(1);
    end
  endtask

  // Scoreboard: a handshake at the next rising edge retires the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
      chk("sb_expected", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_ch", evt_if.evt_ch, e.ch);
        chk("sb_pol", evt_if.evt_pol, e.pol);
      end
    end
  end

  initial begin
    sig              = 4'b0101;
    mode_rise        = 4'b1111;
    mode_fall        = 4'b1111;
    ovf_clr          = 1'b0;
    evt_if.evt_ready = 1'b0;
    #2 rst_n = 1'b0;
    step(2);

    // Reset values
    chk("rst_valid", evt_if.evt_valid, 1'b0);
    chk("rst_ch", evt_if.evt_ch, 2'd0);
    chk("rst_pol", evt_if.evt_pol, 1'b0);
    chk("rst_ovf", ovf, 4'b0000);

    // 1. Reset prime: inputs high at release raise nothing
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("prime_no_valid", evt_if.evt_valid, 1'b0);
    end
    chk("prime_ovf", ovf, 4'b0000);

    // 2. Single rise on ch0 (falls suppressed by mode)
    mode_rise = 4'b0001;
    mode_fall = 4'b0000;
    sig       = 4'b0000;
    step(2);
    chk("single_idle", evt_if.evt_valid, 1'b0);
    evt_if.evt_ready = 1'b1;
    sig = 4'b0001;
    push(2'd0, 1'b1);
    step(1);
    chk("single_t1", evt_if.evt_valid, 1'b0);
    step(1);
    chk("single_t2_valid", evt_if.evt_valid, 1'b1);
    chk("single_ch", evt_if.evt_ch, 2'd0);
    chk("single_pol", evt_if.evt_pol, 1'b1);
    step(1);
    chk("single_one_cycle", evt_if.evt_valid, 1'b0);

    // 3. Simultaneous edges: two batches, both starting at ch0
    do_reset(4'b0000);
    mode_rise = 4'b1111;
    mode_fall = 4'b1111;
    sig = 4'b1111;
    for (int k = 0; k < 4; k++) push(k[1:0], 1'b1);
    batch(1'b1);
    sig = 4'b0000;
    for (int k = 0; k < 4; k++) push(k[1:0], 1'b0);
    batch(1'b0);

    // 4. Backpressure on ch2, ch1 queued behind it
    evt_if.evt_ready = 1'b0;
    sig = 4'b0100;
    push(2'd2, 1'b1);
    step(2);
    sig = 4'b0110;
    push(2'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", evt_if.evt_valid, 1'b1);
      chk("bp_ch", evt_if.evt_ch, 2'd2);
      chk("bp_pol", evt_if.evt_pol, 1'b1);
      step(1);
    end
    evt_if.evt_ready = 1'b1;
    step(1);
    chk("bp_after_hs", evt_if.evt_valid, 1'b0);
    step(1);
    chk("bp_next_valid", evt_if.evt_valid, 1'b1);
    chk("bp_next_ch", evt_if.evt_ch, 2'd1);
    step(1);
    chk("bp_drained", evt_if.evt_valid, 1'b0);

    // 5. Overflow on ch3
    evt_if.evt_ready = 1'b0;
    sig = 4'b1110;
    push(2'd3, 1'b1);
    step(1);
    chk("ovf_not_yet", ovf, 4'b0000);
    sig = 4'b0110;
    step(1);
    chk("ovf_set", ovf, 4'b1000);
    chk("ovf_keep_ch", evt_if.evt_ch, 2'd3);
    chk("ovf_keep_pol", evt_if.evt_pol, 1'b1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 4'b0000);
    sig     = 4'b1110;
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_clr_race", ovf, 4'b1000);
    chk("ovf_still_pol", evt_if.evt_pol, 1'b1);
    evt_if.evt_ready = 1'b1;
    step(1);
    chk("ovf_hs_done", evt_if.evt_valid, 1'b0);

    // 6. Reset while offering with two events pending
    evt_if.evt_ready = 1'b0;
    sig = 4'b0111;
    step(2);
    chk("mid_valid", evt_if.evt_valid, 1'b1);
    chk("mid_ch", evt_if.evt_ch, 2'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_drop", evt_if.evt_valid, 1'b0);
    chk("mid_rst_ovf", ovf, 4'b0000);
    step(2);
    rst_n = 1'b1;
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("mid_no_stale", evt_if.evt_valid, 1'b0);
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel edge-event controller that owns a bank of per-channel edge detectors and shares a single event-reporting port among them. Each channel detects rising and/or falling edges on its input, holds one pending event, and competes through a round-robin arbiter for the shared valid/ready output. The block sits between the sequential edge-detection datapath and any downstream consumer, such as an interrupt or status logger, that takes one event at a time.

## Interface
- `NCH`, default 4: number of input channels; legal range 2..16.
- `CW`, default `$clog2(NCH)`: channel-index width; derived, not overridden.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous assert, active-low (`0` = reset).
- `sig` in NCH: channel inputs, already synchronous to `clk`.
- `mode_rise` in NCH: per-channel rising-edge enable.
- `mode_fall` in NCH: per-channel falling-edge enable.
- `evt_valid` out 1: an event is offered.
- `evt_ready` in 1: the consumer accepts the offered event.
- `evt_ch` out CW: channel index of the offered event.
- `evt_pol` out 1: event polarity; `1` = rising, `0` = falling.
- `ovf` out NCH: sticky per-channel lost-event flags.
- `ovf_clr` in 1: synchronous clear of all `ovf` bits.

## Operation
- **Detection.** Each channel registers `sig_q`.
  - rise = `sig & ~sig_q & mode_rise`; fall = `~sig & sig_q & mode_fall`.
  - Both conditions can never be true in the same cycle.
- **Prime cycle.** The first clock edge after reset deassertion loads `sig_q` from `sig` with detection disabled. No event is raised for an input that is already high at reset release.
- **Pending.** Each channel holds a `pend` bit and a `pol` bit.
  - A detection sets `pend` and stores `pol`.
  - A detection while `pend` is already set is dropped: the oldest event is kept and `ovf[i]` is set.
  - Exception: if the same channel's pending event completes its handshake in that cycle, the new event becomes pending and `ovf` is not set.
- **Disabling a channel.** Clearing `mode_*` does not cancel an event that is already pending.
- **FSM states:** `IDLE`, `OFFER`.
  - `IDLE`: if any `pend` bit is set, select a channel round-robin, starting with the channel after `last_ptr`. Register `evt_ch`/`evt_pol` and go to `OFFER`. Otherwise stay in `IDLE`.
  - `OFFER`: `evt_valid`=1. `evt_ch` and `evt_pol` stay stable while `evt_ready`=0.
  - On `evt_valid & evt_ready`: clear that channel's `pend`, set `last_ptr`=`evt_ch`, return to `IDLE`.
- **Overflow clear.** `ovf_clr` clears all `ovf` bits. An overflow occurring in the same cycle takes priority, and that bit stays set.
- **Reset values.**
  - Outputs: `evt_valid`=0, `evt_ch`=0, `evt_pol`=0, `ovf`=0.
  - Internal: `pend`=0, `sig_q`=0, `last_ptr`=NCH-1 (so channel 0 wins first), state=`IDLE`, prime flag armed.
- **Reset mid-operation.** Asserting `rst` during `OFFER` drops `evt_valid` immediately (asynchronously). All pending events are discarded.

## Timing
- Suppose `sig` changes after edge t0 and the block is idle with no competing channel.
  - `pend` is set at edge t1.
  - `evt_valid` is high after edge t2.
  - Latency: 2 cycles.
- A handshake at edge tn returns the FSM to `IDLE`. The next offer is valid after edge tn+1. Peak throughput is one event per 2 cycles.
- `evt_valid` is never deasserted without a handshake, except by reset.
- `ovf` sets one edge after the dropped detection.

## Structure
- Package `edge_arb_pkg` holds:
  - `typedef enum logic {POL_FALL=1'b0, POL_RISE=1'b1} evt_pol_e`
  - `typedef enum logic {IDLE, OFFER} arb_state_e`
  - `localparam NCH_MAX = 16`
- Sub-module `edge_capture_ch` handles one channel and is instantiated `NCH` times via `generate`.
  - Contents: `sig_q`, prime gating, `pend`/`pol`/`ovf` registers.
  - Inputs: `sig`, `mode_rise`, `mode_fall`, `clr_pend`, `ovf_clr`, `prime`.
- The top level holds the round-robin selector, the FSM and the output registers.

## Test plan
1. **Reset prime.** With `sig`=4'b0101 during reset and both modes enabled, release `rst`; hold `sig` → no `evt_valid` for 10 cycles, `ovf`=0.
2. **Single rise.** `mode_rise`=4'b0001, `evt_ready`=1; `sig[0]` goes 0→1 after edge t0 → `evt_valid` after t2 with `evt_ch`=0, `evt_pol`=1, for one cycle only.
3. **Simultaneous edges.** Rising edges on all 4 channels in one cycle, `evt_ready`=1 → events arrive in order ch0, ch1, ch2, ch3, each 2 cycles apart. A further batch is served starting at ch0 again (`last_ptr`=3).
4. **Backpressure.** `evt_ready`=0 for 5 cycles while ch2 is offered → `evt_ch`=2 and `evt_pol` are stable. An extra edge on ch1 stays pending and is offered after the ch2 handshake.
5. **Overflow.** With `evt_ready`=0, toggle `sig[3]` 0→1→0 with both modes on → `ovf[3]`=1 and the first event (`pol`=1) is kept. Pulse `ovf_clr` → `ovf[3]`=0. `ovf_clr` in the same cycle as a new overflow → `ovf[3]` stays 1.
6. **Reset mid-offer.** Assert `rst` while `evt_valid`=1 with 2 events pending → `evt_valid`=0 immediately. After release, no stale events are offered.
